// File: rtl/axi_lite_cmd_master_if.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_master_if
//
// Purpose: bundles the command/response stream and the five AXI4-Lite
// channels used by axi_lite_cmd_master.
//
// Modports:
//   master - the view of axi_lite_cmd_master: it consumes commands, produces
//            responses, and drives the AXI-Lite request side.
//   slave  - the view of everything around it: the command source, the
//            response sink and the AXI-Lite slave.
//
// Signal groups:
//   cmd_*          command stream (valid/ready, write, addr, wdata, wstrb)
//   rsp_*          response stream (valid/ready, write, rdata, resp)
//   m_axi_aw*/w*   write address and write data channels
//   m_axi_b*       write response channel
//   m_axi_ar*/r*   read address and read data channels
// ---------------------------------------------------------------------------
interface axi_lite_cmd_master_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Command stream
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_wstrb;

    // Response stream
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;

    // AXI write address / data / response
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    // AXI read address / data
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        input  rsp_ready,
        output m_axi_awaddr, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        output rsp_ready,
        input  m_axi_awaddr, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_master
//
// Purpose: single-outstanding AXI4-Lite master. Each accepted command becomes
// one AXI-Lite write (AW and W issued together, completing independently) or
// one read, and produces exactly one response on the rsp_* stream. Every
// output is driven straight from a flop.
//
// Ports:
//   m_axi_aclk     in   clock, rising edge
//   m_axi_areset   in   synchronous active-high reset
//   bus            axi_lite_cmd_master_if.master: cmd_*, rsp_*, m_axi_*
//   stat_wr_cnt    out  16  completed writes          (AXI_CMD_MASTER_STATS_EN)
//   stat_rd_cnt    out  16  completed reads           (AXI_CMD_MASTER_STATS_EN)
//   stat_err_cnt   out  16  responses with resp != 0  (AXI_CMD_MASTER_STATS_EN)
//
// Configuration macro: AXI_CMD_MASTER_STATS_EN adds the three wrapping
// statistics counters and their ports; without it they do not exist.
// ---------------------------------------------------------------------------
module axi_lite_cmd_master #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        m_axi_aclk,
    input  logic                        m_axi_areset,
    axi_lite_cmd_master_if.master       bus
`ifdef AXI_CMD_MASTER_STATS_EN
    ,
    output logic [15:0]                 stat_wr_cnt,
    output logic [15:0]                 stat_rd_cnt,
    output logic [15:0]                 stat_err_cnt
`endif
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_e;

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;

    logic aw_fire;
    logic w_fire;
    logic rsp_fire;

`ifdef AXI_CMD_MASTER_STATS_EN
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
`endif

    // Handshakes are judged on the registered VALID/READY the bus actually sees.
    assign aw_fire  = awvalid_q && bus.m_axi_awready;
    assign w_fire   = wvalid_q && bus.m_axi_wready;
    assign rsp_fire = rsp_valid_q && bus.rsp_ready;

    // State register and all output flops. Reset parks everything at zero,
    // including cmd_ready, which then rises on the first edge out of reset.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // Next-state and next-output logic. Every flop holds by default; each
    // state only touches what changes on its own handshake, which is what
    // keeps a raised VALID up until the matching READY is sampled.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (bus.cmd_write) begin
                        state_d   = WR_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        awaddr_d  = bus.cmd_addr;
                        wdata_d   = bus.cmd_wdata;
                        wstrb_d   = bus.cmd_wstrb;
                    end else begin
                        state_d   = RD_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = bus.cmd_addr;
                    end
                end
            end

            // AW and W retire independently; the phase ends once both have,
            // whether on the same edge or the later of two.
            WR_AW_W: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                end
            end

            WR_B: begin
                if (bready_q && bus.m_axi_bvalid) begin
                    state_d     = RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bus.m_axi_bresp;
                end
            end

            RD_AR: begin
                if (arvalid_q && bus.m_axi_arready) begin
                    state_d   = RD_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end

            RD_R: begin
                if (rready_q && bus.m_axi_rvalid) begin
                    state_d     = RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = bus.m_axi_rdata;
                    rsp_resp_d  = bus.m_axi_rresp;
                end
            end

            // cmd_ready only comes back after the response is taken, so no
            // new command can be accepted on the response handshake edge.
            RSP: begin
                if (rsp_fire) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    awaddr_d    = '0;
                    araddr_d    = '0;
                    wdata_d     = '0;
                    wstrb_d     = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_write     = rsp_write_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_resp      = rsp_resp_q;
    assign bus.m_axi_awaddr  = awaddr_q;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;

`ifdef AXI_CMD_MASTER_STATS_EN
    // Statistics registers; they count on the response handshake so a
    // transaction aborted by reset is never counted.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            wr_cnt_q  <= 16'h0000;
            rd_cnt_q  <= 16'h0000;
            err_cnt_q <= 16'h0000;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Counter increments; plain 16-bit adds wrap from FFFF to 0.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        err_cnt_d = err_cnt_q;
        if (rsp_fire) begin
            if (rsp_write_q) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end else begin
                rd_cnt_d = rd_cnt_q + 16'd1;
            end
            if (rsp_resp_q != 2'b00) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    assign stat_wr_cnt  = wr_cnt_q;
    assign stat_rd_cnt  = rd_cnt_q;
    assign stat_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_cmd_master
//
// Directed bench for axi_lite_cmd_master. A behavioural register-file slave
// with controllable READYs and forced BRESP sits on the AXI side; scenarios
// drive commands through the interface and compare responses and bus
// behaviour against hand-computed values. Build with AXI_CMD_MASTER_STATS_EN
// to also cover the statistics counters.
// ---------------------------------------------------------------------------
module tb_axi_lite_cmd_master;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    axi_lite_cmd_master_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

`ifdef AXI_CMD_MASTER_STATS_EN
    logic [15:0] stat_wr_cnt;
    logic [15:0] stat_rd_cnt;
    logic [15:0] stat_err_cnt;
`endif

    axi_lite_cmd_master #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .m_axi_aclk   (clk),
        .m_axi_areset (rst),
        .bus          (bus)
`ifdef AXI_CMD_MASTER_STATS_EN
        ,
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_rd_cnt  (stat_rd_cnt),
        .stat_err_cnt (stat_err_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Slave controls
    logic       awready_ctl = 1'b1;
    logic       wready_ctl  = 1'b1;
    logic       arready_ctl = 1'b1;
    logic [1:0] bresp_ctl   = 2'b00;

    assign bus.m_axi_awready = awready_ctl;
    assign bus.m_axi_wready  = wready_ctl;
    assign bus.m_axi_arready = arready_ctl;

    // Slave state
    logic [31:0] mem [0:63];
    logic        aw_have = 1'b0;
    logic        w_have  = 1'b0;
    logic [5:0]  aw_addr_l;
    logic [31:0] w_data_l;
    logic [3:0]  w_strb_l;
    int          commit_count = 0;

    logic        bvalid_r = 1'b0;
    logic [1:0]  bresp_r  = 2'b00;
    logic        rvalid_r = 1'b0;
    logic [31:0] rdata_r  = 32'h0;

    assign bus.m_axi_bvalid = bvalid_r;
    assign bus.m_axi_bresp  = bresp_r;
    assign bus.m_axi_rvalid = rvalid_r;
    assign bus.m_axi_rdata  = rdata_r;
    assign bus.m_axi_rresp  = 2'b00;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    end

    // Register-file slave: commits a write once both AW and W have been seen
    // and answers B on the next cycle; answers R one cycle after AR.
    always @(posedge clk) begin
        logic        aw_now;
        logic        w_now;
        logic [5:0]  a_now;
        logic [31:0] d_now;
        logic [3:0]  s_now;
        logic [31:0] word;
        if (rst) begin
            aw_have  <= 1'b0;
            w_have   <= 1'b0;
            bvalid_r <= 1'b0;
            rvalid_r <= 1'b0;
        end else begin
            aw_now = aw_have || (bus.m_axi_awvalid && bus.m_axi_awready);
            w_now  = w_have  || (bus.m_axi_wvalid && bus.m_axi_wready);
            a_now  = aw_have ? aw_addr_l : bus.m_axi_awaddr;
            d_now  = w_have ? w_data_l : bus.m_axi_wdata;
            s_now  = w_have ? w_strb_l : bus.m_axi_wstrb;
            if (bvalid_r && bus.m_axi_bready) bvalid_r <= 1'b0;
            if (aw_now && w_now) begin
                word = mem[a_now];
                for (int b = 0; b < 4; b++) begin
                    if (s_now[b]) word[8*b +: 8] = d_now[8*b +: 8];
                end
                mem[a_now]   <= word;
                commit_count = commit_count + 1;
                bvalid_r     <= 1'b1;
                bresp_r      <= bresp_ctl;
                aw_have      <= 1'b0;
                w_have       <= 1'b0;
            end else begin
                if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                    aw_have   <= 1'b1;
                    aw_addr_l <= bus.m_axi_awaddr;
                end
                if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                    w_have   <= 1'b1;
                    w_data_l <= bus.m_axi_wdata;
                    w_strb_l <= bus.m_axi_wstrb;
                end
            end
            if (rvalid_r && bus.m_axi_rready) rvalid_r <= 1'b0;
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                rvalid_r <= 1'b1;
                rdata_r  <= mem[bus.m_axi_araddr];
            end
        end
    end

    // Protocol watch and accept/response logging on pre-edge values.
    int   cyc = 0;
    int   valid_drop = 0;
    logic aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0, rsp_pend = 1'b0;
    int   accept_q[$];
    logic [34:0] rsp_q[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            aw_pend  = 1'b0;
            w_pend   = 1'b0;
            ar_pend  = 1'b0;
            rsp_pend = 1'b0;
        end else begin
            if (aw_pend && !bus.m_axi_awvalid) valid_drop++;
            if (w_pend && !bus.m_axi_wvalid) valid_drop++;
            if (ar_pend && !bus.m_axi_arvalid) valid_drop++;
            if (rsp_pend && !bus.rsp_valid) valid_drop++;
            aw_pend  = bus.m_axi_awvalid && !bus.m_axi_awready;
            w_pend   = bus.m_axi_wvalid && !bus.m_axi_wready;
            ar_pend  = bus.m_axi_arvalid && !bus.m_axi_arready;
            rsp_pend = bus.rsp_valid && !bus.rsp_ready;
            if (bus.cmd_valid && bus.cmd_ready) accept_q.push_back(cyc);
            if (bus.rsp_valid && bus.rsp_ready)
                rsp_q.push_back({bus.rsp_write, bus.rsp_resp, bus.rsp_rdata});
        end
    end

    // Presents one command and returns on the negedge after it is accepted.
    task automatic issue_cmd(input logic w, input logic [5:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_wstrb = s;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.cmd_ready) begin
            errors++;
            $display("[TB] FAIL cmd_accept_timeout: cmd_ready=%b required 1", bus.cmd_ready);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_wstrb = '0;
    endtask

    // Waits for rsp_valid; lat counts cycles from the accepting edge.
    task automatic wait_rsp(output logic rw, output logic [1:0] rr,
                            output logic [31:0] rd, output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!bus.rsp_valid) begin
            errors++;
            $display("[TB] FAIL rsp_timeout: rsp_valid=%b required 1", bus.rsp_valid);
        end
        rw = bus.rsp_write;
        rr = bus.rsp_resp;
        rd = bus.rsp_rdata;
        if (bus.rsp_ready) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0;   bus.cmd_wstrb = '0;   bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.m_axi_awvalid, bus.m_axi_wvalid,
             bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshakes: got %b required 0000000",
                     {bus.cmd_ready, bus.rsp_valid, bus.m_axi_awvalid, bus.m_axi_wvalid,
                      bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready});
        end
        checks++;
        if ({bus.rsp_write, bus.rsp_resp, bus.rsp_rdata} !== 35'h0) begin
            errors++;
            $display("[TB] FAIL reset_rsp_payload: got %h required 0",
                     {bus.rsp_write, bus.rsp_resp, bus.rsp_rdata});
        end
        checks++;
        if ({bus.m_axi_awaddr, bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_araddr} !== 48'h0) begin
            errors++;
            $display("[TB] FAIL reset_addr_data: got %h required 0",
                     {bus.m_axi_awaddr, bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_araddr});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_cmd_ready: got %b required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write_read;
        logic rw; logic [1:0] rr; logic [31:0] rd; int lat;
        issue_cmd(1'b1, 6'h01, 32'h1111_0001, 4'b1111);
        wait_rsp(rw, rr, rd, lat);
        checks++;
        if ({rw, rr, rd} !== {1'b1, 2'b00, 32'h0}) begin
            errors++;
            $display("[TB] FAIL write_rsp: got w=%b resp=%b data=%h required w=1 resp=00 data=0", rw, rr, rd);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("[TB] FAIL write_latency: got %0d required 3", lat);
        end
        issue_cmd(1'b0, 6'h01, 32'h0, 4'b0);
        wait_rsp(rw, rr, rd, lat);
        checks++;
        if ({rw, rr, rd} !== {1'b0, 2'b00, 32'h1111_0001}) begin
            errors++;
            $display("[TB] FAIL read_rsp: got w=%b resp=%b data=%h required w=0 resp=00 data=11110001", rw, rr, rd);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("[TB] FAIL read_latency: got %0d required 3", lat);
        end
    endtask

    task automatic test_split_handshake;
        logic rw; logic [1:0] rr; logic [31:0] rd; int lat; int c0;
        c0 = commit_count;
        wready_ctl = 1'b0;
        issue_cmd(1'b1, 6'h04, 32'hAAAA_0004, 4'b1111);
        checks++;
        if ({bus.m_axi_awvalid, bus.m_axi_wvalid} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL split_issue: aw/w valid=%b required 11", {bus.m_axi_awvalid, bus.m_axi_wvalid});
        end
        @(negedge clk);
        checks++;
        if ({bus.m_axi_awvalid, bus.m_axi_wvalid} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL split_aw_first: aw/w valid=%b required 01", {bus.m_axi_awvalid, bus.m_axi_wvalid});
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL split_w_held: aw/w/bready=%b required 010",
                     {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready});
        end
        wready_ctl = 1'b1;
        wait_rsp(rw, rr, rd, lat);
        checks++;
        if ({rw, rr} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL split_rsp: got w=%b resp=%b required w=1 resp=00", rw, rr);
        end
        checks++;
        if (commit_count - c0 !== 1) begin
            errors++;
            $display("[TB] FAIL split_commits: got %0d required 1", commit_count - c0);
        end
        issue_cmd(1'b0, 6'h04, 32'h0, 4'b0);
        wait_rsp(rw, rr, rd, lat);
        checks++;
        if (rd !== 32'hAAAA_0004) begin
            errors++;
            $display("[TB] FAIL split_readback: got %h required AAAA0004", rd);
        end
    endtask

    task automatic test_byte_strobes;
        logic rw; logic [1:0] rr; logic [31:0] rd; int lat;
        issue_cmd(1'b1, 6'h04, 32'hDEAD_BEEF, 4'b0011);
        wait_rsp(rw, rr, rd, lat);
        issue_cmd(1'b0, 6'h04, 32'h0, 4'b0);
        wait_rsp(rw, rr, rd, lat);
        checks++;
        if (rd !== 32'hAAAA_BEEF) begin
            errors++;
            $display("[TB] FAIL strobe_readback: got %h required AAAABEEF", rd);
        end
    endtask

    task automatic test_backpressure;
        logic rw; logic [1:0] rr; logic [31:0] rd; int lat;
        bus.rsp_ready = 1'b0;
        issue_cmd(1'b1, 6'h06, 32'h5A5A_0006, 4'b1111);
        wait_rsp(rw, rr, rd, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_write, bus.rsp_resp, bus.rsp_rdata}
                    !== {1'b1, 1'b0, 1'b1, 2'b00, 32'h0}) begin
                errors++;
                $display("[TB] FAIL bp_hold_%0d: valid=%b cmd_ready=%b w=%b resp=%b data=%h required 1 0 1 00 0",
                         i, bus.rsp_valid, bus.cmd_ready, bus.rsp_write, bus.rsp_resp, bus.rsp_rdata);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bp_release: rsp_valid/cmd_ready=%b required 01", {bus.rsp_valid, bus.cmd_ready});
        end
    endtask

    task automatic test_error_resp;
        logic rw; logic [1:0] rr; logic [31:0] rd; int lat;
        bresp_ctl = 2'b10;
        issue_cmd(1'b1, 6'h07, 32'h0000_0007, 4'b1111);
        wait_rsp(rw, rr, rd, lat);
        bresp_ctl = 2'b00;
        checks++;
        if ({rw, rr} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL err_resp: got w=%b resp=%b required w=1 resp=10", rw, rr);
        end
`ifdef AXI_CMD_MASTER_STATS_EN
        checks++;
        if ({stat_wr_cnt, stat_rd_cnt, stat_err_cnt} !== {16'd5, 16'd3, 16'd1}) begin
            errors++;
            $display("[TB] FAIL err_stats: wr=%0d rd=%0d err=%0d required 5 3 1",
                     stat_wr_cnt, stat_rd_cnt, stat_err_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [34:0] e;
        int n;
        for (int pass = 0; pass < 2; pass++) begin
            accept_q.delete();
            rsp_q.delete();
            @(negedge clk);
            for (int i = 1; i <= 5; i++) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_write = (pass == 0);
                bus.cmd_addr  = 6'(i);
                bus.cmd_wdata = 32'h1111_0000 | 32'(i);
                bus.cmd_wstrb = 4'b1111;
                n = 0;
                while (!bus.cmd_ready && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                @(negedge clk);
            end
            bus.cmd_valid = 1'b0;
            n = 0;
            while (rsp_q.size() < 5 && n < 100) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (rsp_q.size() !== 5 || accept_q.size() !== 5) begin
                errors++;
                $display("[TB] FAIL b2b_count_%0d: rsp=%0d accepts=%0d required 5 5",
                         pass, rsp_q.size(), accept_q.size());
            end else begin
                for (int i = 1; i < 5; i++) begin
                    checks++;
                    if (accept_q[i] - accept_q[i-1] !== 4) begin
                        errors++;
                        $display("[TB] FAIL b2b_spacing_%0d_%0d: got %0d required 4",
                                 pass, i, accept_q[i] - accept_q[i-1]);
                    end
                end
                for (int i = 0; i < 5; i++) begin
                    e = (pass == 0) ? {1'b1, 2'b00, 32'h0}
                                    : {1'b0, 2'b00, 32'h1111_0000 | 32'(i + 1)};
                    checks++;
                    if (rsp_q[i] !== e) begin
                        errors++;
                        $display("[TB] FAIL b2b_rsp_%0d_%0d: got %h required %h", pass, i, rsp_q[i], e);
                    end
                end
            end
        end
        checks++;
        if (valid_drop !== 0) begin
            errors++;
            $display("[TB] FAIL valid_stability: drops=%0d required 0", valid_drop);
        end
    endtask

    task automatic test_reset_mid_write;
        logic rw; logic [1:0] rr; logic [31:0] rd; int lat;
        awready_ctl = 1'b0;
        wready_ctl  = 1'b0;
        issue_cmd(1'b1, 6'h02, 32'hFFFF_FFFF, 4'b1111);
        checks++;
        if (bus.m_axi_awvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_awvalid: got %b required 1", bus.m_axi_awvalid);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.m_axi_awvalid, bus.m_axi_wvalid,
             bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready, bus.m_axi_awaddr} !== 13'b0) begin
            errors++;
            $display("[TB] FAIL midrst_dropped: got %b required 0",
                     {bus.cmd_ready, bus.rsp_valid, bus.m_axi_awvalid, bus.m_axi_wvalid,
                      bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready, bus.m_axi_awaddr});
        end
        @(negedge clk);
        rst = 1'b0;
        awready_ctl = 1'b1;
        wready_ctl  = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_idle: cmd_ready=%b required 1", bus.cmd_ready);
        end
        issue_cmd(1'b1, 6'h02, 32'h1234_5678, 4'b1111);
        wait_rsp(rw, rr, rd, lat);
        checks++;
        if ({rw, rr, lat} !== {1'b1, 2'b00, 32'd3}) begin
            errors++;
            $display("[TB] FAIL midrst_write: got w=%b resp=%b lat=%0d required 1 00 3", rw, rr, lat);
        end
        issue_cmd(1'b0, 6'h02, 32'h0, 4'b0);
        wait_rsp(rw, rr, rd, lat);
        checks++;
        if (rd !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL midrst_readback: got %h required 12345678", rd);
        end
`ifdef AXI_CMD_MASTER_STATS_EN
        checks++;
        if ({stat_wr_cnt, stat_rd_cnt, stat_err_cnt} !== {16'd1, 16'd1, 16'd0}) begin
            errors++;
            $display("[TB] FAIL midrst_stats: wr=%0d rd=%0d err=%0d required 1 1 0",
                     stat_wr_cnt, stat_rd_cnt, stat_err_cnt);
        end
`endif
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] starting axi_lite_cmd_master scenarios");
        test_reset();
        test_write_read();
        test_split_handshake();
        test_byte_strobes();
        test_backpressure();
        test_error_resp();
        test_back_to_back();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation time exceeded");
        $fatal(1, "[TB] global timeout");
    end

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream into AXI-Lite write or read transactions and returns one response per command. It is the initiator-side counterpart of `axi_lite_regs_if`. It drives register-file slaves from internal sequencers and control FSMs without a CPU. Exactly one transaction is in flight at a time; AW and W are issued together and may complete independently.

## Interface
Parameters:
- `ADDR_WIDTH`, 6: AXI address width.
- `DATA_WIDTH`, 32: AXI data width; must be a multiple of 8.
- `STRB_WIDTH`, DATA_WIDTH/8: derived; not to be overridden.

Ports:
- `m_axi_aclk`  in  1: the single clock; all logic is on its rising edge.
- `m_axi_areset`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1 / `cmd_ready`  out  1: command handshake.
- `cmd_write`  in  1: 1 selects write, 0 selects read.
- `cmd_addr`  in  ADDR_WIDTH / `cmd_wdata`  in  DATA_WIDTH / `cmd_wstrb`  in  STRB_WIDTH: command payload; data and strobe are ignored for reads.
- `rsp_valid`  out  1 / `rsp_ready`  in  1: response handshake.
- `rsp_write`  out  1: copy of `cmd_write` for the completed command.
- `rsp_rdata`  out  DATA_WIDTH: read data; 0 for writes.
- `rsp_resp`  out  2: the BRESP or RRESP received.
- `m_axi_awaddr` out ADDR_WIDTH, `m_axi_awvalid` out 1, `m_axi_awready` in 1: AXI write address channel.
- `m_axi_wdata` out DATA_WIDTH, `m_axi_wstrb` out STRB_WIDTH, `m_axi_wvalid` out 1, `m_axi_wready` in 1: AXI write data channel.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1: AXI write response channel.
- `m_axi_araddr` out ADDR_WIDTH, `m_axi_arvalid` out 1, `m_axi_arready` in 1: AXI read address channel.
- `m_axi_rdata` in DATA_WIDTH, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1: AXI read data channel.

## Operation
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE: `cmd_ready`=1. When `cmd_valid` is high, capture the command. A write goes to WR_AW_W with `awvalid`=`wvalid`=1. A read goes to RD_AR with `arvalid`=1.
- WR_AW_W:
  - `awvalid` drops on the edge where `awvalid&&awready` is sampled. `wvalid` drops on the edge where `wvalid&&wready` is sampled. The two are tracked independently with `aw_done` and `w_done` flags.
  - If both complete on the same edge, or the second one completes, go to WR_B.
- WR_B: `bready`=1. On `bvalid&&bready`, latch `bresp` into `rsp_resp`, set `rsp_rdata`=0 and `rsp_write`=1, and go to RSP.
- RD_AR: hold `arvalid`/`araddr` until `arready`, then go to RD_R.
- RD_R: `rready`=1. On `rvalid&&rready`, latch `rdata`/`rresp`, set `rsp_write`=0, and go to RSP.
- RSP: `rsp_valid`=1 and the payload is stable until `rsp_ready`, then return to IDLE.
- Address and data outputs hold the captured command for the whole transaction and are zeroed on return to IDLE.
- Once asserted, a VALID is never deasserted before its handshake.
- Non-OKAY responses are forwarded unchanged and are not retried.

## Timing
- Every output is registered.
- Reset values: all VALID/READY outputs 0 except `cmd_ready`, which is 1 in IDLE one cycle after reset release. All address, data, strobe, `rsp_*` outputs are 0. State is IDLE.
- Minimum latency with a zero-wait slave:
  - Command accepted at edge 0.
  - AW/W or AR valid high during cycle 1.
  - `bready`/`rready` high during cycle 2.
  - `rsp_valid` high during cycle 3.
- Throughput with a zero-wait slave: one command per 4 cycles (accept at edge 0, cycles 1–3 as above, back in IDLE during cycle 4) when `rsp_ready`=1.
- `cmd_ready`=0 in every state except IDLE. No command is accepted in the cycle `rsp_valid&&rsp_ready` fires; the next accept is possible one cycle later.
- `bvalid` or `rvalid` arriving before the matching READY is asserted is held by the slave, and the handshake completes on the first cycle READY is high.
- Reset mid-transaction drops all VALID/READY and returns to IDLE immediately. The attached slave must be reset in the same cycle.

## Configuration
- `AXI_CMD_MASTER_STATS_EN`: when defined, the block adds these outputs:
  - `stat_wr_cnt` out 16: completed writes.
  - `stat_rd_cnt` out 16: completed reads.
  - `stat_err_cnt` out 16: responses with `resp`≠2'b00.
- Each counter increments on the RSP handshake, wraps from 16'hFFFF to 0, and clears on reset.
- When the macro is undefined, these ports and the counter logic do not exist.

## Test plan
- Write then read against `axi_lite_regs_if` with a memory model:
  - Write 6'h01 ← 32'h1111_0001, strb 4'b1111: `rsp_resp`=00 and `rsp_write`=1.
  - Read 6'h01: `rsp_rdata`=32'h1111_0001.
- Split handshake: `wready` delayed 3 cycles after `awready` on a write of 32'hAAAA_0004 to 6'h04. `awvalid` drops first and `wvalid` stays high until its handshake. Exactly one write commit occurs and the readback is 32'hAAAA_0004.
- Byte strobes: write 32'hDEAD_BEEF with strb 4'b0011 over 32'hAAAA_0004: the readback is 32'hAAAA_BEEF.
- Backpressure:
  - Hold `rsp_ready`=0 for 5 cycles: `rsp_valid` and the payload stay stable and `cmd_ready` stays 0.
  - Slave holds `bvalid` with `bresp`=2'b10: `rsp_resp`=2'b10 and, with `AXI_CMD_MASTER_STATS_EN`, `stat_err_cnt`=1.
- Back-to-back: 5 queued writes to 6'h01–6'h05, then 5 reads. Every read returns 32'h1111_000N for address N. No VALID drops before its handshake, and zero-wait spacing is 4 cycles per command.
- Reset mid-write: assert `m_axi_areset` while `awvalid`=1. The next cycle all VALID/READY are 0 and the state is IDLE. A subsequent write of 32'h1234_5678 to 6'h02 completes normally.
